// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front-end sharing one APB master among NREQ requesters,
// one outstanding command at a time, with an ACCESS timeout.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     transfer,
  output logic                     READ_WRITE,
  output logic [ADDR_W-1:0]        apb_write_paddr,
  output logic [DATA_W-1:0]        apb_write_data,
  output logic [ADDR_W-1:0]        apb_read_paddr,
  input  logic                     mst_done,
  input  logic [DATA_W-1:0]        apb_read_data_out,
  input  logic                     PSLVERR
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, win, idx;
  logic [PW:0] sum;
  logic any;
  logic write_q, write_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  // Scan downward so the closest valid requester at or after ptr overwrites the rest.
  always_comb begin
    win = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      idx = sum >= (PW+1)'(NREQ) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      if (req_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: if (any) begin
        state_d = ACCESS;
        gnt_d   = win;
        write_d = req_write[win];
        addr_d  = req_addr[win*ADDR_W +: ADDR_W];
        wdata_d = req_wdata[win*DATA_W +: DATA_W];
        cnt_d   = '0;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mst_done || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = RESP;
          err_d       = mst_done ? PSLVERR : 1'b1;
          rdata_d     = (mst_done && !write_q) ? apb_read_data_out : '0;
          rsp_valid_d = NREQ'(1) << gnt_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = gnt_q == PW'(NREQ - 1) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign req_ready       = (state_q == IDLE && any) ? NREQ'(1) << win : '0;
  assign transfer        = state_q == ACCESS;
  assign READ_WRITE      = transfer & ~write_q;
  assign apb_write_paddr = (transfer && write_q) ? addr_q : '0;
  assign apb_write_data  = (transfer && write_q) ? wdata_q : '0;
  assign apb_read_paddr  = (transfer && !write_q) ? addr_q : '0;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;
  assign rsp_err         = err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed and randomized checks of apb_req_arbiter against a spec-level model.
module tb_apb_req_arbiter;
  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic [3:0] req_valid = '0, req_write = '0;
  logic [35:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata, apb_write_data;
  logic       rsp_err, transfer, READ_WRITE;
  logic [8:0] apb_write_paddr, apb_read_paddr;
  logic       mst_done = 1'b0, PSLVERR = 1'b0;
  logic [7:0] apb_read_data_out = '0;
  int pass_cnt = 0, total = 0, cyc = 0, exp_ptr = 0;
  logic [3:0] obs_ready, obs_rsp, obs_after;
  logic [8:0] obs_waddr, obs_raddr;
  logic [7:0] obs_wdata, obs_rdata;
  logic       obs_rw, obs_err;
  int         obs_n, obs_cyc;

  apb_req_arbiter #(.NREQ(4), .ADDR_W(9), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .mst_done(mst_done),
    .apb_read_data_out(apb_read_data_out), .PSLVERR(PSLVERR));

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  function automatic int winner(input logic [3:0] m, input int p);
    for (int i = 0; i < 4; i++) if (m[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  task automatic set_cmd(input int k, input logic w, input logic [8:0] a, input logic [7:0] d);
    req_write[k] = w;
    req_addr[k*9 +: 9] = a;
    req_wdata[k*8 +: 8] = d;
  endtask

  // Drives one command from IDLE and plays the master: mst_done after lat ACCESS cycles
  // (never if lat is 0 or above the timeout). Returns at the following IDLE negedge.
  task automatic do_txn(input logic [3:0] m, input int lat, input logic err, input logic [7:0] rd);
    req_valid = m;
    #1 obs_ready = req_ready;
    obs_n = 0; obs_rsp = '0; obs_cyc = 0;
    obs_waddr = 'x; obs_raddr = 'x; obs_wdata = 'x; obs_rw = 'x; obs_rdata = 'x; obs_err = 'x;
    for (int c = 0; c < 40 && obs_rsp == 0; c++) begin
      @(negedge PCLK);
      req_valid = '0;
      if (transfer) begin
        obs_n++;
        if (obs_n == 1) begin
          obs_waddr = apb_write_paddr; obs_raddr = apb_read_paddr;
          obs_wdata = apb_write_data; obs_rw = READ_WRITE;
        end
        mst_done = obs_n == lat;
        apb_read_data_out = obs_n == lat ? rd : 8'($urandom);
        PSLVERR = obs_n == lat ? err : 1'($urandom);
      end else begin
        mst_done = 1'b0;
      end
      if (rsp_valid != 0) begin
        obs_rsp = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err; obs_cyc = cyc;
      end
    end
    @(negedge PCLK);
    obs_after = rsp_valid;
  endtask

  task automatic do_reset();
    PRESET = 1'b1; req_valid = '0; mst_done = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL reset_ready: got %b want 0001", req_ready); else pass_cnt++;
    total++; if ({transfer, READ_WRITE} !== 2'b00) $display("FAIL reset_ctrl: got %b want 00", {transfer, READ_WRITE}); else pass_cnt++;
    total++; if ({apb_write_paddr, apb_write_data, apb_read_paddr} !== 26'h0) $display("FAIL reset_bus: got %h want 0", {apb_write_paddr, apb_write_data, apb_read_paddr}); else pass_cnt++;
    total++; if ({rsp_valid, rsp_rdata, rsp_err} !== 13'h0) $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_rdata, rsp_err}); else pass_cnt++;
    req_valid = '0;
    PRESET = 1'b0;
    @(negedge PCLK);
    exp_ptr = 0;
  endtask

  task automatic test_single_write();
    set_cmd(0, 1'b1, 9'h003, 8'h06);
    do_txn(4'b0001, 2, 1'b0, 8'hAA);
    total++; if (obs_ready !== 4'b0001) $display("FAIL wr_ready: got %b want 0001", obs_ready); else pass_cnt++;
    total++; if (obs_n != 2) $display("FAIL wr_len: got %0d want 2", obs_n); else pass_cnt++;
    total++; if ({obs_rw, obs_waddr, obs_wdata, obs_raddr} !== {1'b0, 9'h003, 8'h06, 9'h000}) $display("FAIL wr_bus: got %b %h %h %h want 0 003 06 000", obs_rw, obs_waddr, obs_wdata, obs_raddr); else pass_cnt++;
    total++; if ({obs_rsp, obs_err, obs_rdata} !== {4'b0001, 1'b0, 8'h00}) $display("FAIL wr_rsp: got %b %b %h want 0001 0 00", obs_rsp, obs_err, obs_rdata); else pass_cnt++;
    total++; if (obs_after !== 4'b0000) $display("FAIL wr_pulse: got %b want 0000", obs_after); else pass_cnt++;
    exp_ptr = 1;
  endtask

  task automatic test_single_read();
    set_cmd(2, 1'b0, 9'h105, 8'hEE);
    do_txn(4'b0100, 2, 1'b0, 8'h05);
    total++; if ({obs_rw, obs_raddr, obs_waddr, obs_wdata} !== {1'b1, 9'h105, 9'h000, 8'h00}) $display("FAIL rd_bus: got %b %h %h %h want 1 105 000 00", obs_rw, obs_raddr, obs_waddr, obs_wdata); else pass_cnt++;
    total++; if ({obs_rsp, obs_err, obs_rdata} !== {4'b0100, 1'b0, 8'h05}) $display("FAIL rd_rsp: got %b %b %h want 0100 0 05", obs_rsp, obs_err, obs_rdata); else pass_cnt++;
    exp_ptr = 3;
  endtask

  task automatic test_round_robin();
    int prev;
    do_reset();
    prev = 0;
    for (int k = 0; k < 4; k++) set_cmd(k, 1'b1, 9'(k), 8'(k));
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 2, 1'b0, 8'h00);
      total++; if (obs_rsp !== 4'(1 << (i % 4))) $display("FAIL rr_grant%0d: got %b want %b", i, obs_rsp, 4'(1 << (i % 4))); else pass_cnt++;
      if (i > 0) begin
        total++; if (obs_cyc - prev != 4) $display("FAIL rr_spacing%0d: got %0d want 4", i, obs_cyc - prev); else pass_cnt++;
      end
      prev = obs_cyc;
    end
    exp_ptr = 1;
  endtask

  task automatic test_timeout();
    set_cmd(1, 1'b0, 9'h0F0, 8'h00);
    do_txn(4'b0010, 0, 1'b0, 8'h77);
    total++; if (obs_n != 16) $display("FAIL to_len: got %0d want 16", obs_n); else pass_cnt++;
    total++; if ({obs_rsp, obs_err, obs_rdata} !== {4'b0010, 1'b1, 8'h00}) $display("FAIL to_rsp: got %b %b %h want 0010 1 00", obs_rsp, obs_err, obs_rdata); else pass_cnt++;
    exp_ptr = 2;
  endtask

  task automatic test_slverr();
    set_cmd(2, 1'b1, 9'h20E, 8'h99);
    do_txn(4'b0100, 3, 1'b1, 8'h00);
    total++; if (obs_waddr !== 9'h20E) $display("FAIL err_addr: got %h want 20e", obs_waddr); else pass_cnt++;
    total++; if ({obs_rsp, obs_err} !== {4'b0100, 1'b1}) $display("FAIL err_rsp: got %b %b want 0100 1", obs_rsp, obs_err); else pass_cnt++;
    exp_ptr = 3;
  endtask

  task automatic test_done_at_timeout();
    for (int e = 0; e < 2; e++) begin
      set_cmd(3, 1'b0, 9'h1C4, 8'h00);
      do_txn(4'b1000, 16, 1'(e), 8'h3C);
      total++; if (obs_n != 16) $display("FAIL edge_len%0d: got %0d want 16", e, obs_n); else pass_cnt++;
      total++; if ({obs_rsp, obs_err, obs_rdata} !== {4'b1000, 1'(e), 8'h3C}) $display("FAIL edge_rsp%0d: got %b %b %h want 1000 %0d 3c", e, obs_rsp, obs_err, obs_rdata, e); else pass_cnt++;
    end
    exp_ptr = 0;
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    do_txn(4'b0100, 1, 1'b0, 8'h00);
    set_cmd(3, 1'b1, 9'h0AA, 8'h55);
    req_valid = 4'b1000;
    @(negedge PCLK);
    req_valid = '0;
    total++; if (transfer !== 1'b1) $display("FAIL mid_start: got %b want 1", transfer); else pass_cnt++;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    total++; if ({transfer, rsp_valid} !== 5'b0) $display("FAIL mid_abort: got %b want 00000", {transfer, rsp_valid}); else pass_cnt++;
    seen = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      if (rsp_valid != 0 || transfer) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL mid_quiet: got %b want 0", seen); else pass_cnt++;
    do_txn(4'b1111, 2, 1'b0, 8'h00);
    total++; if (obs_rsp !== 4'b0001) $display("FAIL mid_restart: got %b want 0001", obs_rsp); else pass_cnt++;
    exp_ptr = 1;
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic [7:0] rd;
    logic e, tmo, w;
    int lat, g;
    for (int t = 0; t < 40; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) set_cmd(k, 1'($urandom), 9'($urandom), 8'($urandom));
      lat = $urandom_range(1, 20);
      e = 1'($urandom);
      rd = 8'($urandom);
      g = winner(m, exp_ptr);
      w = req_write[g];
      tmo = lat > 16;
      do_txn(m, lat, e, rd);
      total++; if (obs_ready !== 4'(1 << g) || obs_rsp !== 4'(1 << g)) $display("FAIL rnd_grant%0d: got %b/%b want %b", t, obs_ready, obs_rsp, 4'(1 << g)); else pass_cnt++;
      total++; if (obs_n != (tmo ? 16 : lat)) $display("FAIL rnd_len%0d: got %0d want %0d", t, obs_n, tmo ? 16 : lat); else pass_cnt++;
      total++; if (obs_rw !== ~w || obs_waddr !== (w ? req_addr[g*9 +: 9] : 9'h0) || obs_raddr !== (w ? 9'h0 : req_addr[g*9 +: 9]) || obs_wdata !== (w ? req_wdata[g*8 +: 8] : 8'h0)) $display("FAIL rnd_bus%0d: got %b %h %h %h", t, obs_rw, obs_waddr, obs_raddr, obs_wdata); else pass_cnt++;
      total++; if (obs_err !== (tmo ? 1'b1 : e) || obs_rdata !== ((tmo || w) ? 8'h00 : rd)) $display("FAIL rnd_rsp%0d: got %b %h want %b %h", t, obs_err, obs_rdata, tmo ? 1'b1 : e, (tmo || w) ? 8'h00 : rd); else pass_cnt++;
      exp_ptr = (g + 1) % 4;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_slverr();
    test_done_at_timeout();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
